tag_rx_sched: RTL and testbench

Burst scheduler for the tag RX locate chain. Drives `run_rx` of the tag RX controller and sequences it through listen windows, gated locate bursts and rest periods. It watches the controller's `rx_state` to detect acquisition, locate completion, misses and hangs. It sits between the host/GPIO-level enable and the RX controller, and holds the controller in clear (`run_rx`=0) whenever no listen window is open.

---
 rtl/tag_rx_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_tag_rx_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_rx_sched.sv
// tag_rx_sched: burst scheduler for the tag RX locate chain.
// Sequences run_rx through listen windows, locate bursts and rest periods,
// watching rx_state for acquisition, locate completion, misses and hangs.
//
// Build option: define TAG_RX_SCHED_STATS_EN to build the hit/miss/abort
// statistics counters; without it they read 0 and stats_clr is ignored.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | scheduler disabled, controller held in clear
// ARM    | run_rx low for GAP_CYCLES so controller pipelines flush
// LISTEN | run_rx high, waiting for acquisition (rx_state != 0)
// TRACK  | acquired, waiting for locate completion (rx_state == 0)
// REST   | run_rx low for REST_CYCLES after a full burst or miss run

module tag_rx_sched #(
  parameter int unsigned TMR_WIDTH      = 24,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned LISTEN_TIMEOUT = 1048576,
  parameter int unsigned TRACK_TIMEOUT  = 1048576,
  parameter int unsigned NLOC_PER_BURST = 4,
  parameter int unsigned MAX_MISS       = 8,
  parameter int unsigned REST_CYCLES    = 65536,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sched_en,
  input  logic [1:0]           rx_state,
  input  logic                 stats_clr,
  output logic                 run_rx,
  output logic [2:0]           sched_state,
  output logic                 loc_done_stb,
  output logic                 miss_stb,
  output logic                 abort_stb,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] abort_cnt
);

  localparam int unsigned MISS_W  = $clog2(MAX_MISS + 1);
  localparam int unsigned BURST_W = $clog2(NLOC_PER_BURST + 1);

  localparam logic [TMR_WIDTH-1:0] GAP_LAST    = TMR_WIDTH'(GAP_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] LISTEN_LAST = TMR_WIDTH'(LISTEN_TIMEOUT - 1);
  localparam logic [TMR_WIDTH-1:0] TRACK_LAST  = TMR_WIDTH'(TRACK_TIMEOUT - 1);
  localparam logic [TMR_WIDTH-1:0] REST_LAST   = TMR_WIDTH'(REST_CYCLES - 1);
  localparam logic [MISS_W-1:0]    MISS_LIMIT  = MISS_W'(MAX_MISS);
  localparam logic [BURST_W-1:0]   BURST_LIMIT = BURST_W'(NLOC_PER_BURST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LISTEN = 3'd2,
    S_TRACK  = 3'd3,
    S_REST   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [TMR_WIDTH-1:0] r_tmr, w_tmr_nxt;
  logic [MISS_W-1:0]    r_miss_run, w_miss_run_nxt;
  logic [BURST_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
  logic                 r_run_rx;
  logic                 r_loc_done_stb, r_miss_stb, r_abort_stb;
  logic                 w_loc_stb_nxt, w_miss_stb_nxt, w_abort_stb_nxt;
  logic [MISS_W-1:0]    w_miss_run_inc;
  logic [BURST_W-1:0]   w_burst_cnt_inc;

  assign w_miss_run_inc  = r_miss_run + 1'b1;
  assign w_burst_cnt_inc = r_burst_cnt + 1'b1;

  // Next-state, timer, run counters and strobe decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_tmr_nxt       = r_tmr + 1'b1;
    w_miss_run_nxt  = r_miss_run;
    w_burst_cnt_nxt = r_burst_cnt;
    w_loc_stb_nxt   = 1'b0;
    w_miss_stb_nxt  = 1'b0;
    w_abort_stb_nxt = 1'b0;

    if (!sched_en) begin
      w_state_nxt     = S_IDLE;
      w_tmr_nxt       = '0;
      w_miss_run_nxt  = '0;
      w_burst_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARM;
          w_tmr_nxt   = '0;
        end
        S_ARM: begin
          if (r_tmr == GAP_LAST) begin
            w_state_nxt = S_LISTEN;
            w_tmr_nxt   = '0;
          end
        end
        S_LISTEN: begin
          // Acquisition takes precedence over a coincident timeout.
          if (rx_state != 2'b00) begin
            w_state_nxt    = S_TRACK;
            w_tmr_nxt      = '0;
            w_miss_run_nxt = '0;
          end else if (r_tmr == LISTEN_LAST) begin
            w_miss_stb_nxt = 1'b1;
            w_tmr_nxt      = '0;
            if (w_miss_run_inc == MISS_LIMIT) begin
              w_miss_run_nxt  = '0;
              w_burst_cnt_nxt = '0;
              w_state_nxt     = S_REST;
            end else begin
              w_miss_run_nxt = w_miss_run_inc;
              w_state_nxt    = S_ARM;
            end
          end
        end
        S_TRACK: begin
          // Completion takes precedence over a coincident timeout.
          if (rx_state == 2'b00) begin
            w_loc_stb_nxt = 1'b1;
            w_tmr_nxt     = '0;
            if (w_burst_cnt_inc == BURST_LIMIT) begin
              w_burst_cnt_nxt = '0;
              w_state_nxt     = S_REST;
            end else begin
              w_burst_cnt_nxt = w_burst_cnt_inc;
              w_state_nxt     = S_LISTEN;
            end
          end else if (r_tmr == TRACK_LAST) begin
            w_abort_stb_nxt = 1'b1;
            w_burst_cnt_nxt = '0;
            w_tmr_nxt       = '0;
            w_state_nxt     = S_ARM;
          end
        end
        S_REST: begin
          if (r_tmr == REST_LAST) begin
            w_state_nxt = S_ARM;
            w_tmr_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = '0;
        end
      endcase
    end
  end

  // State, timer, run counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_tmr          <= '0;
      r_miss_run     <= '0;
      r_burst_cnt    <= '0;
      r_run_rx       <= 1'b0;
      r_loc_done_stb <= 1'b0;
      r_miss_stb     <= 1'b0;
      r_abort_stb    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_tmr          <= w_tmr_nxt;
      r_miss_run     <= w_miss_run_nxt;
      r_burst_cnt    <= w_burst_cnt_nxt;
      r_run_rx       <= (w_state_nxt == S_LISTEN) || (w_state_nxt == S_TRACK);
      r_loc_done_stb <= w_loc_stb_nxt;
      r_miss_stb     <= w_miss_stb_nxt;
      r_abort_stb    <= w_abort_stb_nxt;
    end
  end

  assign run_rx       = r_run_rx;
  assign sched_state  = r_state;
  assign loc_done_stb = r_loc_done_stb;
  assign miss_stb     = r_miss_stb;
  assign abort_stb    = r_abort_stb;

`ifdef TAG_RX_SCHED_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_hit_cnt, r_miss_cnt, r_abort_cnt;

  // Saturating statistics, updated on the same edge as their strobes; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_abort_cnt <= '0;
    end else if (stats_clr) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_loc_stb_nxt && (r_hit_cnt != CNT_MAX)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (w_miss_stb_nxt && (r_miss_cnt != CNT_MAX)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (w_abort_stb_nxt && (r_abort_cnt != CNT_MAX)) begin
        r_abort_cnt <= r_abort_cnt + 1'b1;
      end
    end
  end

  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign abort_cnt = r_abort_cnt;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;

  assign hit_cnt   = '0;
  assign miss_cnt  = '0;
  assign abort_cnt = '0;
`endif

endmodule

// File: tb/tb_tag_rx_sched.sv
// Directed bench for tag_rx_sched with small timing parameters and a
// 2-bit statistics width so saturation is reachable quickly.
module tb_tag_rx_sched;

  localparam int CW = 2;
`ifdef TAG_RX_SCHED_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sched_en = 1'b1;
  logic [1:0]    rx_state = 2'b00;
  logic          stats_clr = 1'b0;
  logic          run_rx;
  logic [2:0]    sched_state;
  logic          loc_done_stb, miss_stb, abort_stb;
  logic [CW-1:0] hit_cnt, miss_cnt, abort_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_LISTEN = 3'd2,
                         ST_TRACK = 3'd3, ST_REST = 3'd4;

  tag_rx_sched #(
    .TMR_WIDTH(24), .GAP_CYCLES(4), .LISTEN_TIMEOUT(10), .TRACK_TIMEOUT(20),
    .NLOC_PER_BURST(2), .MAX_MISS(2), .REST_CYCLES(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sched_en(sched_en), .rx_state(rx_state),
    .stats_clr(stats_clr), .run_rx(run_rx), .sched_state(sched_state),
    .loc_done_stb(loc_done_stb), .miss_stb(miss_stb), .abort_stb(abort_stb),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] exp_cnt(input int v);
    return STATS_EN ? CW'(v) : '0;
  endfunction

  // Restart from IDLE and stop on the first LISTEN cycle (timer at 0).
  task automatic go_listen();
    sched_en = 1'b0;
    rx_state = 2'b00;
    step();
    sched_en = 1'b1;
    step();
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sched_en = 1'b1; rx_state = 2'b00;
    #2;
    step();
    checks++;
    if ({run_rx, loc_done_stb, miss_stb, abort_stb} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b want 0000", {run_rx, loc_done_stb, miss_stb, abort_stb});
    end
    checks++;
    if (sched_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", sched_state, ST_IDLE);
    end
    checks++;
    if ({hit_cnt, miss_cnt, abort_cnt} !== '0) begin
      errors++; $display("FAIL reset_counters: got %h want 0", {hit_cnt, miss_cnt, abort_cnt});
    end
  endtask

  task automatic test_miss();
    logic [2:0] st [1:51];
    logic       ms [1:51];
    logic       rr [1:51];
    int first_k = 0, second_k = 0, n_miss = 0, run_total = 0, run_max = 0, run_cur = 0, bad_run = 0;
    reset_n = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      step();
      st[k] = sched_state; ms[k] = miss_stb; rr[k] = run_rx;
      if (k == 29) begin
        checks++;
        if (miss_cnt !== exp_cnt(2)) begin
          errors++; $display("FAIL miss_cnt_two: got %0d want %0d", miss_cnt, exp_cnt(2));
        end
      end
    end
    for (int k = 1; k <= 51; k++) begin
      if (ms[k]) begin
        n_miss++;
        if (first_k == 0) first_k = k; else if (second_k == 0) second_k = k;
      end
      if (rr[k] !== (st[k] == ST_LISTEN || st[k] == ST_TRACK)) bad_run++;
      if (k <= 28) begin
        if (rr[k]) begin run_total++; run_cur++; if (run_cur > run_max) run_max = run_cur; end
        else run_cur = 0;
      end
    end
    checks++;
    if (first_k != 15) begin
      errors++; $display("FAIL first_miss_cycle: got %0d want 15", first_k);
    end
    checks++;
    if (second_k - first_k != 14) begin
      errors++; $display("FAIL miss_spacing: got %0d want 14", second_k - first_k);
    end
    checks++;
    if (st[29] !== ST_REST || st[28] !== ST_LISTEN) begin
      errors++; $display("FAIL rest_on_second_miss: got %0d/%0d want %0d/%0d", st[28], st[29], ST_LISTEN, ST_REST);
    end
    checks++;
    if (run_total != 20 || run_max != 10) begin
      errors++; $display("FAIL run_window: got total %0d max %0d want 20 10", run_total, run_max);
    end
    checks++;
    if (bad_run != 0) begin
      errors++; $display("FAIL run_matches_state: got %0d bad cycles want 0", bad_run);
    end
    checks++;
    if (st[36] !== ST_REST || st[37] !== ST_ARM || st[41] !== ST_LISTEN) begin
      errors++; $display("FAIL rest_length: got %0d/%0d/%0d want 4/1/2", st[36], st[37], st[41]);
    end
    checks++;
    if (st[51] !== ST_ARM || ms[51] !== 1'b1 || n_miss != 3) begin
      errors++; $display("FAIL miss_run_cleared: got state %0d stb %b n %0d want 1 1 3", st[51], ms[51], n_miss);
    end
    checks++;
    if (miss_cnt !== exp_cnt(3)) begin
      errors++; $display("FAIL miss_cnt_saturate: got %0d want %0d", miss_cnt, exp_cnt(3));
    end
  endtask

  task automatic test_stats_clr();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    checks++;
    if (miss_cnt !== '0) begin
      errors++; $display("FAIL stats_clr: got %0d want 0", miss_cnt);
    end
    go_listen();
    repeat (9) step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    checks++;
    if (miss_stb !== 1'b1 || miss_cnt !== '0) begin
      errors++; $display("FAIL clr_beats_incr: got stb %b cnt %0d want 1 0", miss_stb, miss_cnt);
    end
  endtask

  task automatic test_burst();
    int stb_n = 0, run_low = 0, arm_seen = 0;
    go_listen();
    for (int b = 0; b < 2; b++) begin
      rx_state = 2'b01;
      for (int c = 0; c < 5; c++) begin
        step();
        if (!run_rx) run_low++;
        if (sched_state == ST_ARM) arm_seen++;
        if (loc_done_stb) stb_n++;
      end
      rx_state = 2'b00;
      step();
      if (loc_done_stb) stb_n++;
      if (b == 0) begin
        checks++;
        if (sched_state !== ST_LISTEN || run_rx !== 1'b1 || loc_done_stb !== 1'b1) begin
          errors++; $display("FAIL burst_first_locate: got st %0d run %b stb %b want 2 1 1", sched_state, run_rx, loc_done_stb);
        end
      end
    end
    checks++;
    if (sched_state !== ST_REST || run_rx !== 1'b0) begin
      errors++; $display("FAIL burst_rest: got st %0d run %b want 4 0", sched_state, run_rx);
    end
    checks++;
    if (stb_n != 2 || run_low != 0 || arm_seen != 0) begin
      errors++; $display("FAIL burst_continuous: got stb %0d low %0d arm %0d want 2 0 0", stb_n, run_low, arm_seen);
    end
    step();
    checks++;
    if (loc_done_stb !== 1'b0 || hit_cnt !== exp_cnt(2)) begin
      errors++; $display("FAIL burst_hit_cnt: got stb %b cnt %0d want 0 %0d", loc_done_stb, hit_cnt, exp_cnt(2));
    end
  endtask

  task automatic test_hang();
    int early = 0, low_n = 0;
    go_listen();
    rx_state = 2'b01; step();
    rx_state = 2'b00; step();
    rx_state = 2'b11; step();
    for (int c = 0; c < 19; c++) begin
      step();
      if (abort_stb || sched_state != ST_TRACK) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL hang_early_abort: got %0d bad cycles want 0", early);
    end
    step();
    checks++;
    if (abort_stb !== 1'b1 || sched_state !== ST_ARM || run_rx !== 1'b0) begin
      errors++; $display("FAIL hang_abort: got stb %b st %0d run %b want 1 1 0", abort_stb, sched_state, run_rx);
    end
    if (!run_rx) low_n++;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) begin
        checks++;
        if (abort_stb !== 1'b0) begin
          errors++; $display("FAIL abort_one_cycle: got %b want 0", abort_stb);
        end
      end
      if (!run_rx) low_n++;
    end
    checks++;
    if (low_n != 4 || sched_state !== ST_LISTEN) begin
      errors++; $display("FAIL hang_gap: got low %0d st %0d want 4 2", low_n, sched_state);
    end
    step();
    rx_state = 2'b00;
    step();
    checks++;
    if (loc_done_stb !== 1'b1 || sched_state !== ST_LISTEN) begin
      errors++; $display("FAIL burst_cleared_after_abort: got stb %b st %0d want 1 2", loc_done_stb, sched_state);
    end
    checks++;
    if (abort_cnt !== exp_cnt(1) || hit_cnt !== exp_cnt(3)) begin
      errors++; $display("FAIL hang_counts: got abort %0d hit %0d want %0d %0d", abort_cnt, hit_cnt, exp_cnt(1), exp_cnt(3));
    end
  endtask

  task automatic test_simultaneous();
    go_listen();
    repeat (9) step();
    rx_state = 2'b10;
    step();
    checks++;
    if (sched_state !== ST_TRACK || miss_stb !== 1'b0) begin
      errors++; $display("FAIL acq_beats_timeout: got st %0d miss %b want 3 0", sched_state, miss_stb);
    end
    repeat (19) step();
    rx_state = 2'b00;
    step();
    checks++;
    if (loc_done_stb !== 1'b1 || abort_stb !== 1'b0 || sched_state !== ST_LISTEN) begin
      errors++; $display("FAIL done_beats_timeout: got loc %b abort %b st %0d want 1 0 2", loc_done_stb, abort_stb, sched_state);
    end
    checks++;
    if (abort_cnt !== exp_cnt(1)) begin
      errors++; $display("FAIL no_abort_count: got %0d want %0d", abort_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_disable();
    go_listen();
    rx_state = 2'b01; step();
    step();
    sched_en = 1'b0; rx_state = 2'b00;
    step();
    checks++;
    if (sched_state !== ST_IDLE || run_rx !== 1'b0 || {loc_done_stb, miss_stb, abort_stb} !== 3'b000) begin
      errors++; $display("FAIL disable_in_track: got st %0d run %b stb %b want 0 0 000", sched_state, run_rx, {loc_done_stb, miss_stb, abort_stb});
    end
    checks++;
    if (hit_cnt !== exp_cnt(3) || abort_cnt !== exp_cnt(1)) begin
      errors++; $display("FAIL disable_keeps_stats: got hit %0d abort %0d want %0d %0d", hit_cnt, abort_cnt, exp_cnt(3), exp_cnt(1));
    end
  endtask

  task automatic test_reset_mid();
    go_listen();
    step();
    checks++;
    if (run_rx !== 1'b1) begin
      errors++; $display("FAIL pre_reset_listen: got %b want 1", run_rx);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (run_rx !== 1'b0 || sched_state !== ST_IDLE) begin
      errors++; $display("FAIL async_reset: got run %b st %0d want 0 0", run_rx, sched_state);
    end
    checks++;
    if ({loc_done_stb, miss_stb, abort_stb, hit_cnt, miss_cnt, abort_cnt} !== '0) begin
      errors++; $display("FAIL async_reset_all: got %h want 0", {loc_done_stb, miss_stb, abort_stb, hit_cnt, miss_cnt, abort_cnt});
    end
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_stats_clr();
    test_burst();
    test_hang();
    test_simultaneous();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
